ah_grant_mux_slice: RTL and testbench

AH_GRANT_MUX_SLICE -- requirements
Module: ah_grant_mux_slice

---
 rtl/ah_grant_mux_slice_pkg.sv | 14 +
 rtl/ah_grant_mux_slice_onehot_enc.sv | 29 ++
 rtl/ah_grant_mux_slice.sv | 129 ++++++++++++
 tb/tb_ah_grant_mux_slice.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ah_grant_mux_slice_pkg.sv
// Shared arbiter definitions: client geometry and skid-buffer occupancy states.
package ah_grant_mux_slice_pkg;

  localparam int unsigned NUM_CLIENTS = 16;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned IDX_W       = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/ah_grant_mux_slice_onehot_enc.sv
// One-hot to binary encoder with exactly-one and multi-hot detection.
module ah_onehot_enc #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_c_o,
  output logic             onehot_c_o,
  output logic             multi_c_o
);

  logic seen;

  // OR-encode set bit positions; flag a second set bit as multi-hot.
  always_comb begin
    idx_c_o   = '0;
    seen      = 1'b0;
    multi_c_o = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (vec_i[i]) begin
        if (seen) multi_c_o = 1'b1;
        seen    = 1'b1;
        idx_c_o = idx_c_o | IDX_W'(i);
      end
    end
    onehot_c_o = seen & ~multi_c_o;
  end

endmodule

// File: rtl/ah_grant_mux_slice.sv
// Grant-driven payload mux feeding a 2-entry skid buffer with backpressure.
module ah_grant_mux_slice #(
  parameter int unsigned NUM_CLIENTS = ah_grant_mux_slice_pkg::NUM_CLIENTS,
  parameter int unsigned DATA_W      = ah_grant_mux_slice_pkg::DATA_W,
  parameter int unsigned IDX_W       = ah_grant_mux_slice_pkg::IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        gnt_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] data_i,
  output logic [NUM_CLIENTS-1:0]        ack_o,
  output logic                          hold_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [IDX_W-1:0]              out_idx_o,
  output logic                          grant_err_o,
  input  logic                          err_clr_i
);

  import ah_grant_mux_slice_pkg::*;

  occ_state_e        state_q, state_d;
  logic [IDX_W-1:0]  head_idx_q, head_idx_d, tail_idx_q, tail_idx_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  enc_idx;
  logic              enc_onehot;
  logic              enc_multi;
  logic              capture;
  logic              pop;
  logic [DATA_W-1:0] cap_data;

  ah_onehot_enc #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i      (gnt_i),
    .idx_c_o    (enc_idx),
    .onehot_c_o (enc_onehot),
    .multi_c_o  (enc_multi)
  );

  assign cap_data = data_i[enc_idx*DATA_W +: DATA_W];

  // Next-state for occupancy, storage, backpressure and error flag; ack is
  // a same-cycle pulse so it is decoded here from the captured grant.
  always_comb begin
    state_d     = state_q;
    head_idx_d  = head_idx_q;
    head_data_d = head_data_q;
    tail_idx_d  = tail_idx_q;
    tail_data_d = tail_data_q;
    err_d       = err_q;
    ack_o       = '0;

    capture = enc_onehot & ~hold_q & ~rst;
    pop     = (state_q != OCC_EMPTY) & out_ready_i;

    if (capture) ack_o = gnt_i;

    case (state_q)
      OCC_EMPTY: begin
        if (capture) begin
          head_idx_d  = enc_idx;
          head_data_d = cap_data;
          state_d     = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (capture && !pop) begin
          tail_idx_d  = enc_idx;
          tail_data_d = cap_data;
          state_d     = OCC_FULL;
        end else if (capture && pop) begin
          head_idx_d  = enc_idx;
          head_data_d = cap_data;
        end else if (pop) begin
          state_d     = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // hold_q is high here, so no capture can coincide with the promote.
        if (pop) begin
          head_idx_d  = tail_idx_q;
          head_data_d = tail_data_q;
          state_d     = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase

    hold_d = (state_d == OCC_FULL);

    // A new multi-hot grant takes priority over a clear in the same cycle.
    if (enc_multi)      err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OCC_EMPTY;
      head_idx_q  <= '0;
      head_data_q <= '0;
      tail_idx_q  <= '0;
      tail_data_q <= '0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_idx_q  <= head_idx_d;
      head_data_q <= head_data_d;
      tail_idx_q  <= tail_idx_d;
      tail_data_q <= tail_data_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = (state_q != OCC_EMPTY);
  assign out_data_o  = head_data_q;
  assign out_idx_o   = head_idx_q;
  assign hold_o      = hold_q;
  assign grant_err_o = err_q;

endmodule

// File: tb/tb_ah_grant_mux_slice.sv
// Directed and scoreboarded checks for the grant mux skid slice.
module tb_ah_grant_mux_slice;

  localparam int unsigned NC = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     gnt_i;
  logic [NC*DW-1:0]  data_i;
  logic [NC-1:0]     ack_o;
  logic              hold_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DW-1:0]     out_data_o;
  logic [IW-1:0]     out_idx_o;
  logic              grant_err_o;
  logic              err_clr_i;

  int passed = 0;
  int total  = 0;

  ah_grant_mux_slice #(.NUM_CLIENTS(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .gnt_i       (gnt_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .hold_o      (hold_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .grant_err_o (grant_err_o),
    .err_clr_i   (err_clr_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  logic [35:0] q[$];
  logic        exp_hold;
  logic [15:0] exp_ack;
  int          k;

  initial begin
    rst = 1'b1; gnt_i = '0; out_ready_i = 1'b0; err_clr_i = 1'b0;
    for (int i = 0; i < int'(NC); i++) data_i[i*DW +: DW] = pat(i);

    // Reset state, with a grant that must be ignored.
    tick(); gnt_i = 16'h0004; settle();
    chk("rst_ack", 32'(ack_o), 32'h0);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_hold", 32'(hold_o), 32'h0);
    chk("rst_err", 32'(grant_err_o), 32'h0);
    chk("rst_data", out_data_o, 32'h0);
    chk("rst_idx", 32'(out_idx_o), 32'h0);
    tick(); rst = 1'b0; gnt_i = '0; settle();

    // Scenario 1: single capture, one-cycle latency.
    tick(); gnt_i = 16'h0004; data_i[2*DW +: DW] = 32'hDEADBEEF; out_ready_i = 1'b1; settle();
    chk("s1_ack", 32'(ack_o), 32'h0004);
    chk("s1_valid_pre", 32'(out_valid_o), 32'h0);
    tick(); gnt_i = '0; settle();
    chk("s1_valid", 32'(out_valid_o), 32'h1);
    chk("s1_idx", 32'(out_idx_o), 32'd2);
    chk("s1_data", out_data_o, 32'hDEADBEEF);
    chk("s1_ack_off", 32'(ack_o), 32'h0);
    tick(); settle();
    chk("s1_drained", 32'(out_valid_o), 32'h0);
    data_i[2*DW +: DW] = pat(2);

    // Scenario 2: fill to FULL, blocked grant, ordered drain.
    tick(); out_ready_i = 1'b0; gnt_i = 16'h0002; settle();
    chk("s2_ack1", 32'(ack_o), 32'h0002);
    tick(); gnt_i = 16'h0020; settle();
    chk("s2_ack5", 32'(ack_o), 32'h0020);
    chk("s2_hold0", 32'(hold_o), 32'h0);
    chk("s2_idx1a", 32'(out_idx_o), 32'd1);
    tick(); gnt_i = 16'h0200; settle();
    chk("s2_ack9_blk", 32'(ack_o), 32'h0);
    chk("s2_hold1", 32'(hold_o), 32'h1);
    chk("s2_idx1b", 32'(out_idx_o), 32'd1);
    chk("s2_data1", out_data_o, pat(1));
    tick(); out_ready_i = 1'b1; settle();
    chk("s2_ack9_blk2", 32'(ack_o), 32'h0);
    chk("s2_idx1c", 32'(out_idx_o), 32'd1);
    tick(); settle();
    chk("s2_hold_rel", 32'(hold_o), 32'h0);
    chk("s2_idx5", 32'(out_idx_o), 32'd5);
    chk("s2_data5", out_data_o, pat(5));
    chk("s2_ack9", 32'(ack_o), 32'h0200);
    tick(); gnt_i = '0; settle();
    chk("s2_idx9", 32'(out_idx_o), 32'd9);
    chk("s2_data9", out_data_o, pat(9));
    tick(); settle();
    chk("s2_drained", 32'(out_valid_o), 32'h0);

    // Scenario 3: multi-hot grant error, clear, and error-beats-clear.
    tick(); gnt_i = 16'h0003; settle();
    chk("s3_ack", 32'(ack_o), 32'h0);
    chk("s3_err_pre", 32'(grant_err_o), 32'h0);
    tick(); gnt_i = '0; settle();
    chk("s3_err", 32'(grant_err_o), 32'h1);
    chk("s3_nocap", 32'(out_valid_o), 32'h0);
    tick(); err_clr_i = 1'b1; settle();
    tick(); err_clr_i = 1'b0; settle();
    chk("s3_clr", 32'(grant_err_o), 32'h0);
    tick(); gnt_i = 16'h0101; err_clr_i = 1'b1; settle();
    chk("s3_ack2", 32'(ack_o), 32'h0);
    tick(); gnt_i = '0; err_clr_i = 1'b0; settle();
    chk("s3_err_wins", 32'(grant_err_o), 32'h1);
    tick(); err_clr_i = 1'b1; settle();
    tick(); err_clr_i = 1'b0; settle();
    chk("s3_clr2", 32'(grant_err_o), 32'h0);

    // Scenario 4: capture and pop in the same cycle from ONE.
    tick(); out_ready_i = 1'b0; gnt_i = 16'h0008; settle();
    chk("s4_ack3", 32'(ack_o), 32'h0008);
    tick(); gnt_i = 16'h8000; out_ready_i = 1'b1; settle();
    chk("s4_idx3", 32'(out_idx_o), 32'd3);
    chk("s4_ack15", 32'(ack_o), 32'h8000);
    tick(); gnt_i = '0; out_ready_i = 1'b0; settle();
    chk("s4_idx15", 32'(out_idx_o), 32'd15);
    chk("s4_data15", out_data_o, pat(15));
    chk("s4_hold", 32'(hold_o), 32'h0);
    tick(); out_ready_i = 1'b1; settle();
    tick(); settle();
    chk("s4_drained", 32'(out_valid_o), 32'h0);

    // Scenario 5: reset while FULL with a grant present.
    tick(); out_ready_i = 1'b0; gnt_i = 16'h0002; settle();
    tick(); gnt_i = 16'h0004; settle();
    tick(); gnt_i = '0; settle();
    chk("s5_full", 32'(hold_o), 32'h1);
    tick(); rst = 1'b1; gnt_i = 16'h0008; settle();
    chk("s5_rst_ack", 32'(ack_o), 32'h0);
    tick(); rst = 1'b0; gnt_i = '0; settle();
    chk("s5_valid", 32'(out_valid_o), 32'h0);
    chk("s5_hold", 32'(hold_o), 32'h0);

    // Scenario 6: random one-hot grants against a queue model.
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      tick();
      k = int'($urandom_range(0, NC - 1));
      gnt_i = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'h1 << k);
      out_ready_i = 1'($urandom_range(0, 1));
      data_i[k*DW +: DW] = $urandom;
      settle();
      exp_hold = (q.size() == 2);
      exp_ack  = exp_hold ? 16'h0 : gnt_i;
      chk("r_hold", 32'(hold_o), 32'(exp_hold));
      chk("r_ack", 32'(ack_o), 32'(exp_ack));
      chk("r_valid", 32'(out_valid_o), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("r_idx", 32'(out_idx_o), 32'(q[0][35:32]));
        chk("r_data", out_data_o, q[0][31:0]);
        if (out_ready_i) void'(q.pop_front());
      end
      if (exp_ack != 0) q.push_back({4'(k), data_i[k*DW +: DW]});
    end
    tick(); gnt_i = '0; out_ready_i = 1'b1; settle();
    tick(); settle();
    tick(); settle();
    chk("r_drained", 32'(out_valid_o), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
